// File: rtl/mux_n1_scan_pkg.sv
// Shared definitions for the N:1 scan multiplexer family.
// Mode encodings and counter sizing reused by future mux/demux blocks.
package mux_n1_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_nw.sv
// Combinational N:1 selector, W bits per channel.
// Out-of-range idx yields zero.
module mux_nw #(
  parameter int N = 4,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) y = din[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_n1_scan.sv
// N:1 W-bit mux with registered output, manual select or
// auto-scan with per-channel dwell, hold and wrap pulse.
module mux_n1_scan
  import mux_n1_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_L      = (SW+1)'(N);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [SW-1:0] ch_nx;
  logic          valid_nx;
  logic          wrap_nx;
  logic          load;
  logic          sel_ok;
  logic [W-1:0]  mux_y;

  assign sel_ok = ({1'b0, sel} < N_L);

  // Mux is driven by the next channel so dout and ch never skew
  mux_nw #(.N(N), .W(W)) u_mux (
    .din (din),
    .idx (ch_nx),
    .y   (mux_y)
  );

  always_comb begin
    ch_nx    = ch;
    cnt_nx   = cnt;
    valid_nx = valid;
    wrap_nx  = 1'b0;
    load     = 1'b0;
    if (hold) begin
      load = 1'b0;
    end else if (mode == MODE_MANUAL) begin
      load   = 1'b1;
      cnt_nx = '0;
      if (sel_ok) begin
        ch_nx    = sel;
        valid_nx = 1'b1;
      end else begin
        valid_nx = 1'b0;
      end
    end else begin
      load     = 1'b1;
      valid_nx = 1'b1;
      if (cnt == CNT_LAST) begin
        cnt_nx = '0;
        if (ch == CH_LAST) begin
          ch_nx   = '0;
          wrap_nx = 1'b1;
        end else begin
          ch_nx = ch + SW'(1);
        end
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      ch    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      ch    <= ch_nx;
      cnt   <= cnt_nx;
      valid <= valid_nx;
      wrap  <= wrap_nx;
      if (load) dout <= mux_y;
    end
  end

endmodule

// File: tb/tb_mux_n1_scan.sv
// Bench for mux_n1_scan: N=4/DWELL=3 and N=5/DWELL=1 instances,
// position-based reference model plus directed literal checks.
module tb_mux_n1_scan;

  logic        clk;
  logic        rst;

  logic [31:0] din4;
  logic [1:0]  sel4;
  logic        mode4, hold4;
  logic [7:0]  o4_dout;
  logic [1:0]  o4_ch;
  logic        o4_valid, o4_wrap;

  logic [39:0] din5;
  logic [2:0]  sel5;
  logic        mode5, hold5;
  logic [7:0]  o5_dout;
  logic [2:0]  o5_ch;
  logic        o5_valid, o5_wrap;

  int n_chk = 0;
  int n_fail = 0;

  mux_n1_scan #(.N(4), .W(8), .DWELL(3)) u4 (
    .clk   (clk),
    .rst   (rst),
    .din   (din4),
    .sel   (sel4),
    .mode  (mode4),
    .hold  (hold4),
    .dout  (o4_dout),
    .ch    (o4_ch),
    .valid (o4_valid),
    .wrap  (o4_wrap)
  );

  mux_n1_scan #(.N(5), .W(8), .DWELL(1)) u5 (
    .clk   (clk),
    .rst   (rst),
    .din   (din5),
    .sel   (sel5),
    .mode  (mode5),
    .hold  (hold5),
    .dout  (o5_dout),
    .ch    (o5_ch),
    .valid (o5_valid),
    .wrap  (o5_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Scan position model: ch = (base + pos/DWELL) mod N
  typedef struct {
    int ch;
    int dout;
    bit valid;
    bit wrap;
    int base;
    int pos;
    bit scan;
  } mst_t;

  mst_t m[2];

  task automatic mstep(input int i, input int nn, input int dw,
                       input bit r, input bit h, input bit md,
                       input int s, input logic [39:0] d);
    int old;
    if (r) begin
      m[i] = '{default: 0};
    end else if (h) begin
      m[i].wrap = 1'b0;
    end else if (!md) begin
      m[i].scan = 1'b0;
      m[i].wrap = 1'b0;
      if (s < nn) begin
        m[i].ch    = s;
        m[i].valid = 1'b1;
      end else begin
        m[i].valid = 1'b0;
      end
      m[i].dout = int'(d[m[i].ch*8 +: 8]);
    end else begin
      if (!m[i].scan) begin
        m[i].base = m[i].ch;
        m[i].pos  = 0;
        m[i].scan = 1'b1;
      end
      old = m[i].ch;
      m[i].pos++;
      m[i].ch    = (m[i].base + m[i].pos / dw) % nn;
      m[i].wrap  = (old == nn - 1) && (m[i].ch == 0);
      m[i].valid = 1'b1;
      m[i].dout  = int'(d[m[i].ch*8 +: 8]);
    end
  endtask

  always begin
    @(posedge clk);
    mstep(0, 4, 3, rst, hold4, mode4, int'(sel4), {8'h00, din4});
    mstep(1, 5, 1, rst, hold5, mode5, int'(sel5), din5);
    #1;
    chk("m4.dout",  o4_dout,  m[0].dout);
    chk("m4.ch",    o4_ch,    m[0].ch);
    chk("m4.valid", o4_valid, m[0].valid);
    chk("m4.wrap",  o4_wrap,  m[0].wrap);
    chk("m5.dout",  o5_dout,  m[1].dout);
    chk("m5.ch",    o5_ch,    m[1].ch);
    chk("m5.valid", o5_valid, m[1].valid);
    chk("m5.wrap",  o5_wrap,  m[1].wrap);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         sc_ch[12] = '{0,0,1,1,1,2,2,2,3,3,3,0};
  logic [7:0] b4[4]     = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int         s5_ch[6]  = '{0,1,2,3,4,0};

  initial begin
    rst   = 1'b1;
    din4  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    sel4  = 2'd0;
    mode4 = 1'b0;
    hold4 = 1'b0;
    din5  = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    sel5  = 3'd0;
    mode5 = 1'b0;
    hold5 = 1'b0;
    tick(2);
    chk("rst.dout",  o4_dout,  0);
    chk("rst.ch",    o4_ch,    0);
    chk("rst.valid", o4_valid, 0);
    chk("rst.wrap",  o4_wrap,  0);

    rst  = 1'b0;
    sel4 = 2'd2;
    tick(1);
    chk("man.dout",  o4_dout,  8'hCC);
    chk("man.ch",    o4_ch,    2);
    chk("man.valid", o4_valid, 1);

    sel4 = 2'd0;
    tick(1);
    chk("pre.ch", o4_ch, 0);
    mode4 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("scan.ch",   o4_ch,   sc_ch[k]);
      chk("scan.dout", o4_dout, b4[sc_ch[k]]);
      chk("scan.wrap", o4_wrap, (k == 11));
    end

    tick(4);
    chk("hpre.ch", o4_ch, 1);
    hold4 = 1'b1;
    mode4 = 1'b0;
    din4  = {8'hDD, 8'hCC, 8'hB1, 8'hAA};
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("hold.ch",   o4_ch,   1);
      chk("hold.dout", o4_dout, 8'hBB);
      chk("hold.wrap", o4_wrap, 0);
    end
    hold4 = 1'b0;
    mode4 = 1'b1;
    tick(1);
    chk("rel1.ch",   o4_ch,   1);
    chk("rel1.dout", o4_dout, 8'hB1);
    tick(1);
    chk("rel2.ch",   o4_ch,   2);
    chk("rel2.dout", o4_dout, 8'hCC);

    tick(2);
    chk("sw.pre", o4_ch, 2);
    mode4 = 1'b0;
    sel4  = 2'd0;
    tick(1);
    chk("sw.ch",   o4_ch,   0);
    chk("sw.wrap", o4_wrap, 0);
    chk("sw.dout", o4_dout, 8'hAA);
    mode4 = 1'b1;
    tick(1);
    chk("back1.ch", o4_ch, 0);
    tick(1);
    chk("back2.ch", o4_ch, 0);
    tick(1);
    chk("back3.ch",   o4_ch,   1);
    chk("back3.dout", o4_dout, 8'hB1);

    tick(3);
    chk("arst.pre", o4_ch, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.dout",  o4_dout,  0);
    chk("arst.ch",    o4_ch,    0);
    chk("arst.valid", o4_valid, 0);
    chk("arst.wrap",  o4_wrap,  0);
    chk("arst.ch5",   o5_ch,    0);
    @(negedge clk);
    rst   = 1'b0;
    mode4 = 1'b0;

    sel5 = 3'd2;
    tick(1);
    chk("n5.ch",    o5_ch,    2);
    chk("n5.dout",  o5_dout,  8'h33);
    sel5 = 3'd6;
    din5 = {8'h55, 8'h44, 8'h3F, 8'h22, 8'h11};
    tick(1);
    chk("bad.ch",    o5_ch,    2);
    chk("bad.valid", o5_valid, 0);
    chk("bad.dout",  o5_dout,  8'h3F);
    sel5 = 3'd4;
    tick(1);
    chk("s4.ch",    o5_ch,    4);
    chk("s4.valid", o5_valid, 1);
    chk("s4.dout",  o5_dout,  8'h55);

    mode5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("d1.ch",   o5_ch,   s5_ch[k]);
      chk("d1.wrap", o5_wrap, (k == 0 || k == 5));
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
